// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel
// slew-limited angle tracking, and pulse width/enable latched only at frame wrap.
module servo_pwm_multi #(
  parameter int unsigned CHANNELS      = 6,
  parameter int unsigned PERIOD_CYCLES = 240000,
  parameter int unsigned MIN_PULSE     = 6000,
  parameter int unsigned STEP_PER_DEG  = 133,
  parameter int unsigned MAX_ANGLE     = 180,
  parameter int unsigned SLEW_MAX      = 180,
  parameter int unsigned RESET_ANGLE   = 90,
  parameter int unsigned CNT_W         = 18,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [7:0]          wr_angle,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start,
  output logic [CHANNELS-1:0] settled
);

  localparam logic [7:0] MAX_A   = (MAX_ANGLE > 255) ? 8'd255 : 8'(MAX_ANGLE);
  // 255 exceeds any possible angle difference, so the slew limit never engages
  localparam logic [7:0] SLEW_A  = ((SLEW_MAX >= MAX_ANGLE) || (SLEW_MAX > 255)) ? 8'd255
                                                                                : 8'(SLEW_MAX);
  localparam logic [7:0] RESET_A = 8'(RESET_ANGLE);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_WIDTH = CNT_W'(MIN_PULSE + RESET_ANGLE * STEP_PER_DEG);

  if (MIN_PULSE + MAX_ANGLE * STEP_PER_DEG >= PERIOD_CYCLES) begin : g_width_guard
    $error("servo_pwm_multi: maximum pulse width does not fit in the frame period");
  end
  if (PERIOD_CYCLES - 1 >= (64'd1 << CNT_W)) begin : g_cnt_guard
    $error("servo_pwm_multi: CNT_W too narrow for PERIOD_CYCLES-1");
  end

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fs_q, fs_d;
  logic                cnt_wrap;
  logic [7:0]          wr_clamped;
  logic [7:0]          target_q [CHANNELS];
  logic [7:0]          target_d [CHANNELS];
  logic [7:0]          cur_q    [CHANNELS];
  logic [7:0]          cur_d    [CHANNELS];
  logic [CNT_W-1:0]    width_q  [CHANNELS];
  logic [CNT_W-1:0]    width_d  [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;

  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] diff;
    logic [7:0] res;
    res = tgt;
    if (tgt >= cur) begin
      diff = tgt - cur;
      if (diff > SLEW_A) res = cur + SLEW_A;
    end else begin
      diff = cur - tgt;
      if (diff > SLEW_A) res = cur - SLEW_A;
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] pulse_width(input logic [7:0] angle);
    return CNT_W'(MIN_PULSE) + CNT_W'(angle) * CNT_W'(STEP_PER_DEG);
  endfunction

  always_comb begin
    cnt_wrap   = (cnt_q == CNT_LAST);
    cnt_d      = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    fs_d       = (cnt_d == '0);
    wr_clamped = (wr_angle > MAX_A) ? MAX_A : wr_angle;
    en_d       = cnt_wrap ? ch_enable : en_q;
    target_d   = target_q;
    cur_d      = cur_q;
    width_d    = width_q;
    // Frame update reads target_q, so a write on the wrap edge waits one frame
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cnt_wrap) begin
        cur_d[i]   = slew_step(cur_q[i], target_q[i]);
        width_d[i] = pulse_width(cur_d[i]);
      end
      if (wr_en && (wr_ch == CH_W'(i))) target_d[i] = wr_clamped;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      fs_q  <= 1'b0;
      en_q  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        target_q[i] <= RESET_A;
        cur_q[i]    <= RESET_A;
        width_q[i]  <= RESET_WIDTH;
      end
    end else begin
      cnt_q    <= cnt_d;
      fs_q     <= fs_d;
      en_q     <= en_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      width_q  <= width_d;
    end
  end

  always_comb begin
    pwm_out = '0;
    settled = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_out[i] = en_q[i] & (cnt_q < width_q[i]);
      settled[i] = (cur_q[i] == target_q[i]);
    end
  end

  // Registered so it stays low while reset holds the counter at zero
  assign frame_start = fs_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: two instances (no slew limit / 10-degree slew)
// share stimulus; per-frame high-cycle counts are compared against hand-computed widths.
module tb_servo_pwm_multi;

  localparam int unsigned P = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [7:0] wr_angle;
  logic [5:0] ch_enable;
  logic [5:0] pwm_f, pwm_s, settled_f, settled_s;
  logic       fs_f, fs_s;

  always #5 clk = ~clk;

  servo_pwm_multi #(.CHANNELS(6), .PERIOD_CYCLES(P), .MIN_PULSE(50), .STEP_PER_DEG(2),
                    .MAX_ANGLE(180), .SLEW_MAX(180), .RESET_ANGLE(90), .CNT_W(9)) dut_f (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
    .ch_enable(ch_enable), .pwm_out(pwm_f), .frame_start(fs_f), .settled(settled_f));

  servo_pwm_multi #(.CHANNELS(6), .PERIOD_CYCLES(P), .MIN_PULSE(50), .STEP_PER_DEG(2),
                    .MAX_ANGLE(180), .SLEW_MAX(10), .RESET_ANGLE(90), .CNT_W(9)) dut_s (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
    .ch_enable(ch_enable), .pwm_out(pwm_s), .frame_start(fs_s), .settled(settled_s));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame monitor: high-cycle count per channel per frame, frame index, position
  int unsigned acc_f [6];
  int unsigned acc_s [6];
  int unsigned last_f [6];
  int unsigned last_s [6];
  int unsigned frame_no = 0;
  int unsigned pos = 0;
  int unsigned gap_f = 0, gap_s = 0;
  logic        seen_f = 1'b0, seen_s = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      seen_f <= 1'b0;
      seen_s <= 1'b0;
      gap_f  <= 0;
      gap_s  <= 0;
      for (int c = 0; c < 6; c++) begin
        acc_f[c] <= 0;
        acc_s[c] <= 0;
      end
    end else begin
      gap_f <= gap_f + 1;
      gap_s <= gap_s + 1;
      if (fs_s) begin
        if (seen_s) check("frame_gap_s", gap_s + 1, P);
        gap_s  <= 0;
        seen_s <= 1'b1;
      end
      if (fs_f) begin
        if (seen_f) check("frame_gap_f", gap_f + 1, P);
        gap_f    <= 0;
        seen_f   <= 1'b1;
        pos      <= 0;
        frame_no <= frame_no + 1;
        for (int c = 0; c < 6; c++) begin
          last_f[c] <= acc_f[c];
          last_s[c] <= acc_s[c];
          acc_f[c]  <= 32'(pwm_f[c]);
          acc_s[c]  <= 32'(pwm_s[c]);
        end
      end else begin
        pos <= pos + 1;
        for (int c = 0; c < 6; c++) begin
          acc_f[c] <= acc_f[c] + 32'(pwm_f[c]);
          acc_s[c] <= acc_s[c] + 32'(pwm_s[c]);
        end
      end
    end
  end

  task automatic wait_frame(input int unsigned tgt);
    int unsigned n = 0;
    int unsigned limit;
    limit = (tgt > frame_no) ? (tgt - frame_no + 2) * P : 2 * P;
    while ((frame_no < tgt) && (n < limit)) begin
      @(negedge clk); #1;
      n++;
    end
    if (frame_no < tgt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: at frame %0d waiting for %0d", frame_no, tgt);
    end
  endtask

  task automatic wait_pos(input int unsigned p);
    int unsigned n = 0;
    logic hit = 1'b0;
    while (!hit && (n < 2 * P)) begin
      @(negedge clk); #1;
      n++;
      if (pos == p) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pos_timeout: counter position %0d never seen, last %0d", p, pos);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] a);
    wr_en = 1'b1; wr_ch = ch; wr_angle = a;
    @(negedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_all(input string tag, input int unsigned ef, input int unsigned es);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("%s_f_ch%0d", tag, c), last_f[c], ef);
      check($sformatf("%s_s_ch%0d", tag, c), last_s[c], es);
    end
  endtask

  typedef struct packed {
    logic            do_wr;
    logic [2:0]      ch;
    logic [7:0]      ang;
    logic [3:0]      nwait;
    logic [5:0][8:0] exp_f;
    logic [5:0][8:0] exp_s;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [5:0][8:0] w6(input int unsigned a0, a1, a2, a3, a4, a5);
    logic [5:0][8:0] r;
    r[0] = 9'(a0); r[1] = 9'(a1); r[2] = 9'(a2);
    r[3] = 9'(a3); r[4] = 9'(a4); r[5] = 9'(a5);
    return r;
  endfunction

  function automatic vec_t mkv(input logic w, input logic [2:0] ch, input logic [7:0] a,
                               input logic [3:0] nw, input logic [5:0][8:0] ef,
                               input logic [5:0][8:0] es);
    vec_t v;
    v.do_wr = w; v.ch = ch; v.ang = a; v.nwait = nw; v.exp_f = ef; v.exp_s = es;
    return v;
  endfunction

  int unsigned fn0;

  task automatic apply_vec(input int i);
    vec_t v;
    v   = vecs[i];
    fn0 = frame_no;
    if (v.do_wr) wr(v.ch, v.ang);
    wait_frame(fn0 + 32'(v.nwait));
    for (int c = 0; c < 6; c++) begin
      check($sformatf("vec%0d_f_ch%0d", i, c), last_f[c], 32'(v.exp_f[c]));
      check($sformatf("vec%0d_s_ch%0d", i, c), last_s[c], 32'(v.exp_s[c]));
    end
  endtask

  initial begin
    // width = 50 + 2*angle; reset angle 90 -> 230
    vecs[0] = mkv(1'b1, 3'd0, 8'd180, 4'd2, w6(410,230,230,230,230,230), w6(250,230,230,230,230,230));
    vecs[1] = mkv(1'b0, 3'd0, 8'd0,   4'd1, w6(410,230,230,230,230,230), w6(270,230,230,230,230,230));
    vecs[2] = mkv(1'b0, 3'd0, 8'd0,   4'd5, w6(410,230,230,230,230,230), w6(370,230,230,230,230,230));
    vecs[3] = mkv(1'b0, 3'd0, 8'd0,   4'd1, w6(410,230,230,230,230,230), w6(410,230,230,230,230,230));
    vecs[4] = mkv(1'b1, 3'd2, 8'd200, 4'd2, w6(410,230,410,230,230,230), w6(410,230,250,230,230,230));
    vecs[5] = mkv(1'b1, 3'd3, 8'd0,   4'd2, w6(410,230,410,50,230,230),  w6(410,230,290,210,230,230));
    vecs[6] = mkv(1'b1, 3'd7, 8'd0,   4'd2, w6(410,230,410,50,230,230),  w6(410,230,330,170,230,230));

    reset = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_angle = '0; ch_enable = 6'h3f;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pwm_f", 32'(pwm_f), 0);
    check("rst_pwm_s", 32'(pwm_s), 0);
    check("rst_fs_f", 32'(fs_f), 0);
    check("rst_settled_f", 32'(settled_f), 32'h3f);
    check("rst_settled_s", 32'(settled_s), 32'h3f);
    reset = 1'b1;

    // Enabled before release: first frame low, then reset-angle pulses
    fn0 = frame_no;
    wait_frame(fn0 + 1);
    check_all("first_frame", 0, 0);
    wait_frame(fn0 + 2);
    check_all("frame2", 230, 230);
    wait_frame(fn0 + 3);
    check_all("frame3", 230, 230);
    check("settled_f_idle", 32'(settled_f), 32'h3f);

    for (int i = 0; i < 3; i++) apply_vec(i);
    // ninth slew update lands exactly on the wrap edge
    wait_pos(P - 1);
    check("settled_s0_pre", 32'(settled_s[0]), 0);
    @(negedge clk); #1;
    check("settled_s0_post", 32'(settled_s[0]), 1);
    check("fs_at_update", 32'(fs_f), 1);
    for (int i = 3; i < 7; i++) apply_vec(i);

    // Enable removed mid-pulse, then writes one cycle either side of the wrap
    fn0 = frame_no;
    wait_pos(100);
    ch_enable = 6'b111101;
    wait_frame(fn0 + 1);
    check("dis_full_f", last_f[1], 230);
    check("dis_full_s", last_s[1], 230);
    wait_frame(fn0 + 2);
    check("dis_off_f", last_f[1], 0);
    check("dis_off_s", last_s[1], 0);
    ch_enable = 6'h3f;
    wait_pos(P - 2);
    wr(3'd1, 8'd0);
    wait_frame(fn0 + 3);
    check("still_off_f", last_f[1], 0);
    wait_frame(fn0 + 4);
    check("wr_p2_f", last_f[1], 50);
    check("wr_p2_s", last_s[1], 210);
    wait_pos(P - 1);
    wr(3'd1, 8'd90);
    wait_frame(fn0 + 6);
    check("wr_p1_late_f", last_f[1], 50);
    check("wr_p1_late_s", last_s[1], 170);
    wait_frame(fn0 + 7);
    check("wr_p1_f", last_f[1], 230);
    check("wr_p1_s", last_s[1], 190);

    // Asynchronous reset in the middle of active pulses
    wait_pos(100);
    check("pre_rst_pwm_f", 32'(pwm_f), 32'b110111);
    check("pre_rst_pwm_s", 32'(pwm_s), 32'b110111);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pwm_f", 32'(pwm_f), 0);
    check("async_rst_pwm_s", 32'(pwm_s), 0);
    repeat (4) @(negedge clk);
    #1;
    check("hold_fs_f", 32'(fs_f), 0);
    check("hold_fs_s", 32'(fs_s), 0);
    check("hold_settled_s", 32'(settled_s), 32'h3f);
    check("hold_pwm_f", 32'(pwm_f), 0);
    reset = 1'b1;
    fn0 = frame_no;
    wait_frame(fn0 + 1);
    check_all("post_rst_low", 0, 0);
    wait_frame(fn0 + 2);
    check_all("post_rst", 230, 230);

    // Back-to-back writes: last write to a channel wins, neighbours unaffected
    fn0 = frame_no;
    wr(3'd4, 8'd10);
    wr(3'd4, 8'd20);
    wr(3'd5, 8'd0);
    wr(3'd6, 8'd0);
    wait_frame(fn0 + 2);
    check("b2b_ch4_f", last_f[4], 90);
    check("b2b_ch5_f", last_f[5], 50);
    check("b2b_ch4_s", last_s[4], 210);
    check("b2b_ch5_s", last_s[5], 210);
    check("b2b_ch0_f", last_f[0], 230);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised multi-channel hobby-servo PWM generator for the arm joints. It drives all CHANNELS outputs from one shared frame counter. Each channel has a target angle written over a simple write port and a slew-limited current angle that steps toward the target once per frame. Pulse widths and enables take effect only at frame boundaries, so no output ever emits a runt or a stretched pulse.

Parameters:
CHANNELS, 6, number of servo outputs (1..16)
PERIOD_CYCLES, 240000, clk cycles per PWM frame (20 ms at 12 MHz)
MIN_PULSE, 6000, pulse width in cycles at angle 0
STEP_PER_DEG, 133, additional pulse cycles per degree
MAX_ANGLE, 180, angle clamp ceiling
SLEW_MAX, 180, max degrees the current angle may move per frame; a value >= MAX_ANGLE means no limiting
RESET_ANGLE, 90, target and current angle after reset
CNT_W, 18, counter and pulse-width width; must hold PERIOD_CYCLES-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  write strobe for a channel target
wr_ch  in  max(1,$clog2(CHANNELS))  channel index for the write
wr_angle  in  8  target angle in degrees
ch_enable  in  CHANNELS  per-channel output enable
pwm_out  out  CHANNELS  servo pulse outputs
frame_start  out  1  one-cycle pulse in the cycle where counter == 0
settled  out  CHANNELS  bit i is 1 when cur_angle[i] == target[i]

Behaviour:
- Frame counter: counts 0..PERIOD_CYCLES-1, then wraps to 0. Free-running while reset is high.
- Write: on a clk edge with wr_en=1 and wr_ch < CHANNELS, target[wr_ch] <= min(wr_angle, MAX_ANGLE).
  - wr_ch >= CHANNELS: write ignored, no state changes.
  - Only one channel can be written per cycle; back-to-back writes are allowed and the last one wins.
- Frame update: on the edge where the counter wraps from PERIOD_CYCLES-1 to 0, every channel updates in parallel:
  - delta = target - cur_angle. If |delta| <= SLEW_MAX, cur_angle <= target. Otherwise cur_angle moves SLEW_MAX degrees toward target.
  - width_lat <= MIN_PULSE + cur_angle_new * STEP_PER_DEG, computed at CNT_W bits with no overflow.
  - en_lat <= ch_enable.
  - The update uses the target value registered before that edge. A write landing on the same edge is applied to target but first affects the next frame.
- Output: pwm_out[i] = en_lat[i] & (counter < width_lat[i]), decoded from registers only.
  - A change of ch_enable or of the target mid-frame never alters the current pulse.
- frame_start = (counter == 0), registered or decoded from the counter; it is high exactly 1 cycle per frame.
- settled[i] is combinational from the registered target[i] and cur_angle[i].
- Reset (reset=0, asynchronous):
  - counter=0
  - target=cur_angle=RESET_ANGLE
  - width_lat = MIN_PULSE + RESET_ANGLE*STEP_PER_DEG (17970 at defaults)
  - en_lat=0, so pwm_out=0 immediately, including mid-pulse
  - frame_start=0 while held in reset; settled=all 1
- After reset release: the first frame has all outputs low. Channels then drive from the first wrap after ch_enable is set.
- Elaboration guard: MIN_PULSE + MAX_ANGLE*STEP_PER_DEG < PERIOD_CYCLES. At defaults, 29940 < 240000.

Test Plan:
1. Reset, then ch_enable=all 1 for 2 frames, no writes -> from frame 2 every pwm_out is high for exactly 17970 cycles per 240000; frame_start is 1 cycle wide with 240000-cycle spacing; settled=all 1.
2. SLEW_MAX=10, write ch0=180 -> ch0 pulse width follows 19300, 20630, … reaching 29940 after 9 frame updates; settled[0] rises in the same cycle as the 9th update; other channels stay at 17970.
3. Write ch2=200, then 0 on ch3 -> ch2 is clamped to 180 (29940 cycles); ch3 gives 6000 cycles (default SLEW_MAX, reached in one frame); a write with wr_ch=7 leaves all widths unchanged.
4. Deassert ch_enable[1] at counter=5000, mid-pulse -> ch1 completes its full 17970-cycle pulse and is low from the next frame. Write ch1=0 at counter=239999 -> the new width appears one frame later than a write at counter=239998.
5. Assert reset at counter=10000 during active pulses -> all pwm_out drop low asynchronously. After release: one full low frame, then pulses at 17970 cycles.
